// File: rtl/tff_seq_pkg.sv
// Shared types for the T flip-flop count sequencer: controller states and
// count-direction encodings.
package tff_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on the rising clock edge whenever t is high,
// and clears asynchronously while rst_n is low.
module tff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= 1'b0;
      else if (t)
         q <= ~q;
   end

endmodule

// File: rtl/tff_count_sequencer.sv
// Command-driven modulo-N up/down counter built from a bank of T flip-flops.
// q is only ever changed through the per-bit toggle vector t.
module tff_count_sequencer
   import tff_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int TICKW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_mod,
   input  logic [TICKW-1:0] cmd_ticks,
   input  logic             pause,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_t             state_reg;
   state_t             state_next;
   logic               dir_reg;
   logic [WIDTH-1:0]   mod_reg;
   logic [TICKW-1:0]   ticks_reg;

   logic [WIDTH-1:0]   t;
   logic [WIDTH-1:0]   up_all;
   logic [WIDTH-1:0]   dn_all;
   logic               at_top;
   logic               at_zero;
   logic               wrap;
   logic               step;
   logic               accept;

   // up_all[i] / dn_all[i]: all lower bits are one / zero (ripple carry / borrow)
   assign up_all[0] = 1'b1;
   assign dn_all[0] = 1'b1;

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign up_all[gi] = up_all[gi-1] &  q[gi-1];
         assign dn_all[gi] = dn_all[gi-1] & ~q[gi-1];
      end
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst),
            .t     (t[gi]),
            .q     (q[gi])
         );
      end
   endgenerate

   assign qb        = ~q;
   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign accept    = cmd_valid & cmd_ready;

   assign at_top  = (q == mod_reg);
   assign at_zero = (q == '0);
   assign wrap    = (dir_reg == DIR_UP) ? at_top : at_zero;
   assign step    = (state_reg == RUN) & ~pause;
   assign tc      = step & wrap;

   // Loading and wrapping toggle exactly the bits that differ from the target.
   always_comb begin
      t = '0;
      case (state_reg)
         LOAD: t = q ^ ((dir_reg == DIR_DN) ? mod_reg : '0);
         RUN: begin
            if (!pause) begin
               if (dir_reg == DIR_UP)
                  t = at_top ? q : up_all;
               else
                  t = at_zero ? mod_reg : dn_all;
            end
         end
         default: t = '0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = LOAD;
         LOAD: state_next = (ticks_reg == '0) ? DONE : RUN;
         RUN:  if (step && ticks_reg == TICKW'(1)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         dir_reg   <= DIR_UP;
         mod_reg   <= '0;
         ticks_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            dir_reg   <= cmd_dir;
            mod_reg   <= cmd_mod;
            ticks_reg <= cmd_ticks;
         end else if (step) begin
            ticks_reg <= ticks_reg - TICKW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: per-cycle expectations from a small
// behavioural counter model, and per-command results checked at the done pulse.
module tb_tff_count_sequencer;

   localparam int WIDTH = 4;
   localparam int TICKW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_dir = 1'b0;
   logic [WIDTH-1:0] cmd_mod = '0;
   logic [TICKW-1:0] cmd_ticks = '0;
   logic             pause = 1'b0;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             tc;
   logic             busy;
   logic             done;

   tff_count_sequencer #(.WIDTH(WIDTH), .TICKW(TICKW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_mod   (cmd_mod),
      .cmd_ticks (cmd_ticks),
      .pause     (pause),
      .q         (q),
      .qb        (qb),
      .tc        (tc),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] q;
      int               tcn;
      int               cyc;
   } res_t;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             tc;
      logic             done;
      logic             busy;
      logic             ready;
   } cyc_t;

   res_t res_q[$];
   cyc_t cyc_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // model state: 0 idle, 1 load, 2 run, 3 done
   int               m_state = 0;
   logic [WIDTH-1:0] m_q = '0;
   logic [WIDTH-1:0] m_mod = '0;
   logic             m_dir = 1'b0;
   int               m_ticks = 0;
   int               m_cyc = 0;
   int               tc_seen = 0;
   int               planned_pauses = 0;
   int               n_accepts = 0;
   int               cycle_no = 0;
   int               last_acc = 0;
   int               prev_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs for this cycle already set.
   task automatic tick();
      cyc_t             e;
      cyc_t             o;
      res_t             r;
      logic [WIDTH-1:0] eqb;
      int               mm;
      #1;
      e.q     = m_q;
      e.busy  = (m_state != 0);
      e.ready = (m_state == 0);
      e.done  = (m_state == 3);
      e.tc    = (m_state == 2) && !pause && ((m_dir == 1'b0) ? (m_q == m_mod) : (m_q == '0));
      cyc_q.push_back(e);
      o   = cyc_q.pop_front();
      eqb = ~o.q;
      chk("q", 32'(q), 32'(o.q));
      chk("qb", 32'(qb), 32'(eqb));
      chk("tc", 32'(tc), 32'(o.tc));
      chk("done", 32'(done), 32'(o.done));
      chk("busy", 32'(busy), 32'(o.busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(o.ready));
      if (done === 1'b1) begin
         chk("done_pending", 32'(res_q.size() != 0), 32'd1);
         if (res_q.size() != 0) begin
            r = res_q.pop_front();
            chk("final_q", 32'(q), 32'(r.q));
            chk("tc_count", 32'(tc_seen), 32'(r.tcn));
            chk("done_cycle", 32'(m_cyc), 32'(r.cyc));
            $display("cmd %0d complete: q=%0d tc_count=%0d done_cycle=%0d", n_accepts, q, tc_seen, m_cyc);
         end
      end
      if (tc === 1'b1) tc_seen++;
      case (m_state)
         0: begin
            if (cmd_valid) begin
               m_dir   = cmd_dir;
               m_mod   = cmd_mod;
               m_ticks = int'(cmd_ticks);
               mm      = int'(m_mod) + 1;
               r.q     = m_dir ? WIDTH'(int'(m_mod) - (m_ticks % mm)) : WIDTH'(m_ticks % mm);
               r.tcn   = m_ticks / mm;
               r.cyc   = m_ticks + 2 + ((m_ticks == 0) ? 0 : planned_pauses);
               res_q.push_back(r);
               tc_seen  = 0;
               m_cyc    = 1;
               n_accepts++;
               prev_acc = last_acc;
               last_acc = cycle_no;
               m_state  = 1;
               $display("accept dir=%0d mod=%0d ticks=%0d at cycle %0d", cmd_dir, cmd_mod, cmd_ticks, cycle_no);
            end
         end
         1: begin
            m_q     = m_dir ? m_mod : '0;
            m_state = (m_ticks == 0) ? 3 : 2;
            m_cyc++;
         end
         2: begin
            if (!pause) begin
               if (m_dir == 1'b0) m_q = (m_q == m_mod) ? '0 : m_q + 1'b1;
               else               m_q = (m_q == '0) ? m_mod : m_q - 1'b1;
               m_ticks--;
               if (m_ticks == 0) m_state = 3;
            end
            m_cyc++;
         end
         default: m_state = 0;
      endcase
      cycle_no++;
      @(negedge clk);
   endtask

   task automatic issue(input logic d, input logic [WIDTH-1:0] m, input logic [TICKW-1:0] tk);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_mod   = m;
      cmd_ticks = tk;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic run_idle();
      for (int i = 0; i < 400 && m_state != 0; i++) tick();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_qb", 32'(qb), 32'hf);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_tc", 32'(tc), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("ready_after_release", 32'(cmd_ready), 32'h1);

      // up count 0..9,0,1,2
      issue(1'b0, 4'd9, 8'd12);
      run_idle();
      chk("up_end_q", 32'(q), 32'd2);

      // down count loading from q=2
      issue(1'b1, 4'd5, 8'd7);
      run_idle();
      chk("down_end_q", 32'(q), 32'd4);

      // pause for 3 cycles after the second step
      planned_pauses = 3;
      issue(1'b0, 4'd15, 8'd4);
      planned_pauses = 0;
      repeat (3) tick();
      chk("pause_hold_q", 32'(q), 32'd2);
      pause = 1'b1;
      repeat (3) tick();
      pause = 1'b0;
      run_idle();
      chk("pause_end_q", 32'(q), 32'd4);

      // ticks=0 with pause high outside RUN
      pause = 1'b1;
      issue(1'b0, 4'd7, 8'd0);
      run_idle();
      pause = 1'b0;
      chk("zero_ticks_q", 32'(q), 32'd0);

      // M=0: stays 0, tc every step
      issue(1'b0, 4'd0, 8'd3);
      run_idle();
      chk("m0_q", 32'(q), 32'd0);

      // full range wrap
      issue(1'b0, 4'd15, 8'd16);
      run_idle();
      chk("full_range_q", 32'(q), 32'd0);

      // async reset mid-RUN at q=6
      issue(1'b0, 4'd15, 8'd10);
      for (int i = 0; i < 20 && !(m_state == 2 && m_q == 4'd6); i++) tick();
      #1;
      chk("pre_reset_q", 32'(q), 32'd6);
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_q", 32'(q), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      $display("async reset applied mid-run");
      m_state = 0;
      m_q     = '0;
      m_dir   = 1'b0;
      m_mod   = '0;
      m_ticks = 0;
      res_q.delete();
      cyc_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      issue(1'b1, 4'd3, 8'd2);
      run_idle();
      chk("post_reset_q", 32'(q), 32'd1);

      // valid held high with changing fields while busy
      begin
         int n0;
         n0        = n_accepts;
         cmd_valid = 1'b1;
         cmd_dir   = 1'b0;
         cmd_mod   = 4'd3;
         cmd_ticks = 8'd3;
         for (int i = 0; i < 40 && n_accepts < n0 + 2; i++) begin
            tick();
            if (n_accepts == n0 + 1 && m_state != 0) begin
               cmd_dir   = 1'($urandom_range(0, 1));
               cmd_mod   = WIDTH'($urandom_range(1, 15));
               cmd_ticks = TICKW'($urandom_range(1, 5));
            end
         end
         cmd_valid = 1'b0;
         chk("accept_count", 32'(n_accepts - n0), 32'd2);
         chk("accept_spacing", 32'(last_acc - prev_acc), 32'd6);
         run_idle();
      end

      tick();
      chk("scoreboard_empty", 32'(res_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tff_count_sequencer.md
# tff_count_sequencer

Command-driven controller that sequences a bank of T flip-flops as a programmable modulo-N up/down counter. It accepts a count command over a valid/ready handshake and loads the start value by toggling only the differing bits. It then issues one T-enable vector per step until the commanded number of steps has elapsed, and signals completion. It sits between a command source (test sequencer or host FSM) and the flip-flop storage, which it owns.

## Interface
- WIDTH, 4: number of T flip-flops (counter bits), ≥2
- TICKW, 8: width of the step-count field

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  0 = count up, 1 = count down
- cmd_mod  in  WIDTH  modulus minus one (terminal value M)
- cmd_ticks  in  TICKW  number of count steps to execute
- pause  in  1  hold counter this cycle (RUN only)
- q  out  WIDTH  flip-flop bank outputs
- qb  out  WIDTH  ~q
- tc  out  1  terminal-count wrap occurring this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Storage: WIDTH T-cells. Each cell toggles on clk when its t bit = 1. The controller never writes q directly; every change of q goes through the t vector.
- Command latch on cmd_valid & cmd_ready: dir, M, ticks_left = cmd_ticks. Inputs are ignored while busy.
- FSM states:
  - IDLE: cmd_ready=1, t=0. On accept, go to LOAD.
  - LOAD: t = q ^ S, with S = 0 (up) or M (down). If ticks_left=0, go to DONE; otherwise go to RUN.
  - RUN: if pause, t=0 and no decrement. Otherwise take one step, decrement ticks_left, and go to DONE when ticks_left reaches 0.
  - DONE: done=1, t=0, go to IDLE.
- Step rules:
  - Up, q≠M: t[0]=1; t[i]=&q[i-1:0].
  - Up, q=M: t = q (wraps to 0), tc=1.
  - Down, q≠0: t[0]=1; t[i]=&~q[i-1:0].
  - Down, q=0: t = M (wraps to M), tc=1.
- tc is combinational: RUN & ~pause & wrap condition.
- M=0: q stays 0, and tc=1 on every non-paused step.
- ticks_left is an unsigned TICKW-bit down-counter and never underflows.
- Reset (async, any state): q=0, qb=all ones, state IDLE, cmd_ready=1 (after release), busy=0, done=0, tc=0, latched fields cleared. Reset mid-RUN abandons the command with no done pulse.

## Timing
- Accept edge E0. State is LOAD during the following cycle; q=S after edge E1.
- With ticks=N>0: steps occur on the next N non-paused RUN edges. DONE follows the edge of the last step, and done is high for exactly one cycle.
- Without pause: done is high in cycle N+2 after E0, and cmd_ready returns the cycle after done. This gives minimum command spacing of N+3 cycles.
- ticks=0: accept, LOAD, DONE, IDLE; q=S and no tc.
- pause in IDLE, LOAD or DONE has no effect.
- cmd_ready is combinational from state only, with no dependence on cmd_valid.

## Structure
- Package tff_seq_pkg: state enum (IDLE, LOAD, RUN, DONE), direction constants DIR_UP=1'b0 and DIR_DN=1'b1.
- Sub-module tff_cell: one T flip-flop with async active-low reset to 0. It is instantiated WIDTH times via generate.
- Top level holds the FSM, command registers, ticks_left counter and t-vector logic.

## Test plan
- Reset then up-count (WIDTH=4, M=9, ticks=12): q goes 0,1,…,9,0,1,2; tc high only on the 9→0 step; done one cycle after q=2; cmd_ready back next cycle.
- Down-count with load from nonzero q (q=2 from prior command; dir=1, M=5, ticks=7): q=5 after LOAD; then 4,3,2,1,0,5,4; tc only on the 0→5 step.
- Pause (up, M=15, ticks=4, pause high for 3 cycles after the 2nd step): q holds at 2 during pause; final q=4; done delayed exactly 3 cycles; ticks unaffected.
- Edge commands:
  - ticks=0 (up): q=0, done at cycle 2, no tc.
  - M=0, ticks=3: q stays 0, tc high 3 times.
  - Full range (M=15, ticks=16, up): q wraps 15→0, ending at 0.
- Async reset asserted mid-RUN at q=6 (between edges): q=0 immediately; busy=0; no done; a new command is accepted after release.
- Busy handshake: cmd_valid held high with changing fields during RUN; no accept until IDLE; the next command is latched exactly on the first cycle cmd_ready=1.
